// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one byte-wide SPI engine between NUM_REQ AXI4-Stream
// requesters; each packet is an atomic transaction under its own chip select.
module spi_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int CS_SETUP_CYC = 2,
  parameter int CS_HOLD_CYC  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            s_tvalid,
  output logic [NUM_REQ-1:0]            s_tready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_REQ-1:0]            s_tlast,
  output logic [NUM_REQ-1:0]            m_tvalid,
  input  logic [NUM_REQ-1:0]            m_tready,
  output logic [NUM_REQ*DATA_WIDTH-1:0] m_tdata,
  output logic [NUM_REQ-1:0]            m_tlast,
  output logic                          spi_start,
  output logic [DATA_WIDTH-1:0]         spi_data_in,
  input  logic [DATA_WIDTH-1:0]         spi_data_out,
  input  logic                          spi_done,
  output logic [NUM_REQ-1:0]            cs_n,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int GW      = $clog2(NUM_REQ);
  localparam int CNT_MAX = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, CS_SETUP, LOAD, XFER, RESP, CS_HOLD} state_t;

  state_t               state;
  logic [GW-1:0]        last_grant;
  logic [CW-1:0]        cnt;
  logic                 last_r;
  logic [GW-1:0]        pick;
  logic [NUM_REQ-1:0]   grant_mask;
  logic [NUM_REQ-1:0]   pick_mask;
  logic                 accept;

  // Nearest requesting index after 'last', wrapping; scanning downward lets the
  // closest candidate overwrite farther ones.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                            input logic [GW-1:0] last);
    logic [GW-1:0] sel;
    int            idx;
    sel = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (req[idx]) sel = GW'(idx);
    end
    return sel;
  endfunction

  assign pick       = rr_pick(s_tvalid, last_grant);
  assign pick_mask  = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
  assign grant_mask = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
  assign s_tready   = (state == LOAD) ? grant_mask : '0;
  assign accept     = (state == LOAD) && ((s_tvalid & grant_mask) != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cs_n        <= '1;
      m_tvalid    <= '0;
      m_tdata     <= '0;
      m_tlast     <= '0;
      spi_start   <= 1'b0;
      spi_data_in <= '0;
      busy        <= 1'b0;
      grant_id    <= '0;
      last_grant  <= GW'(NUM_REQ - 1);
      cnt         <= '0;
      last_r      <= 1'b0;
    end else begin
      spi_start <= 1'b0;
      case (state)
        IDLE: begin
          if (|s_tvalid) begin
            grant_id <= pick;
            cs_n     <= ~pick_mask;
            cnt      <= CW'(CS_SETUP_CYC);
            busy     <= 1'b1;
            state    <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          if (cnt == CW'(1)) state <= LOAD;
          else               cnt   <= cnt - 1'b1;
        end
        // A granted requester that pauses mid-packet simply parks us here with CS low.
        LOAD: begin
          if (accept) begin
            spi_data_in <= s_tdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
            last_r      <= s_tlast[grant_id];
            spi_start   <= 1'b1;
            state       <= XFER;
          end
        end
        XFER: begin
          if (spi_done) begin
            m_tdata[grant_id*DATA_WIDTH +: DATA_WIDTH] <= spi_data_out;
            m_tvalid[grant_id] <= 1'b1;
            m_tlast[grant_id]  <= last_r;
            state              <= RESP;
          end
        end
        RESP: begin
          if (m_tready[grant_id]) begin
            m_tvalid[grant_id] <= 1'b0;
            if (last_r) begin
              cnt   <= CW'(CS_HOLD_CYC);
              state <= CS_HOLD;
            end else begin
              state <= LOAD;
            end
          end
        end
        CS_HOLD: begin
          if (cnt == CW'(1)) begin
            cs_n       <= '1;
            last_grant <= grant_id;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_arbiter.md
Name: spi_arbiter

Overview:
- Shares one byte-wide SPI engine (start/done byte interface) between NUM_REQ AXI4-Stream requesters.
- Each requester owns one chip-select line. A packet (bytes up to and including tlast) is an atomic SPI transaction with its CS held low throughout.
- Round-robin arbitration between packets. Per-byte MISO responses are routed back to the granted requester's response stream.
- Sits between the per-device drivers (flash, ADC, display) and the single spi_master instance.

Parameters:
NUM_REQ, 4, number of requesters/chip selects (2..8)
DATA_WIDTH, 8, byte width of the SPI engine and of all tdata
CS_SETUP_CYC, 2, clk cycles CS is low before the first byte starts (>=1)
CS_HOLD_CYC, 2, clk cycles CS stays low after the last byte's response is accepted (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
s_tvalid  in  NUM_REQ  per-requester command byte valid
s_tready  out  NUM_REQ  per-requester command byte ready
s_tdata  in  NUM_REQ*DATA_WIDTH  command bytes; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH]
s_tlast  in  NUM_REQ  last byte of the transaction
m_tvalid  out  NUM_REQ  per-requester response valid
m_tready  in  NUM_REQ  per-requester response ready
m_tdata  out  NUM_REQ*DATA_WIDTH  MISO byte for each requester, same slicing as s_tdata
m_tlast  out  NUM_REQ  echoes tlast of the matching command byte
spi_start  out  1  one-cycle start pulse to the SPI engine
spi_data_in  out  DATA_WIDTH  byte to shift out
spi_data_out  in  DATA_WIDTH  received byte, valid when spi_done=1
spi_done  in  1  one-cycle completion pulse from the SPI engine
cs_n  out  NUM_REQ  active-low chip selects, at most one low at any time
busy  out  1  high in every state except IDLE
grant_id  out  $clog2(NUM_REQ)  index of the current or most recent grant

Behaviour:
- Reset (async, any state): state=IDLE; cs_n all 1; s_tready=0; m_tvalid=0; m_tdata=0; m_tlast=0; spi_start=0; spi_data_in=0; busy=0; grant_id=0; last_grant=NUM_REQ-1, so that requester 0 has first priority.
- All outputs except s_tready are registered. s_tready[g] is combinational: 1 only in LOAD for g=grant_id; all other bits are 0.
- FSM states: IDLE, CS_SETUP, LOAD, XFER, RESP, CS_HOLD.
- IDLE:
  - If any s_tvalid is high, pick the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - grant_id<=g, cs_n[g]<=0, load counter with CS_SETUP_CYC, go to CS_SETUP.
- CS_SETUP: decrement the counter each cycle. Stay exactly CS_SETUP_CYC cycles, then go to LOAD.
- LOAD:
  - On s_tvalid[g]&&s_tready[g]: spi_data_in<=byte, last_r<=s_tlast[g], spi_start<=1, go to XFER.
  - If the granted requester drops tvalid mid-packet: remain in LOAD with CS held low; other requesters stay blocked.
- XFER:
  - spi_start returns to 0 after exactly one cycle.
  - On spi_done: m_tdata slice g<=spi_data_out, m_tvalid[g]<=1, m_tlast[g]<=last_r, go to RESP.
- RESP:
  - On m_tready[g]: m_tvalid[g]<=0.
  - If last_r, load counter with CS_HOLD_CYC and go to CS_HOLD; otherwise go to LOAD.
  - No new command byte is accepted until the previous response is taken (one byte in flight).
- CS_HOLD: stay CS_HOLD_CYC cycles, then cs_n<=all 1, last_grant<=grant_id, go to IDLE. CS is high for at least one cycle (IDLE) between consecutive transactions.
- spi_done outside XFER is ignored. s_tvalid of non-granted requesters is ignored until IDLE.
- Latency: IDLE request seen at cycle 0 -> cs_n low at cycle 1 -> s_tready high at cycle 1+CS_SETUP_CYC -> spi_start at cycle 2+CS_SETUP_CYC. With the default C=2, spi_start is at cycle 4.
- Single-byte packets (tlast on the first byte) follow the full sequence.
- A requester asserting tvalid continuously cannot starve others: the next packet goes to the next requester in round-robin order.

Test Plan:
- Single request, req1 sends 0xA5 with tlast, engine model returns 0x3C after 8 cycles:
  - cs_n=4'b1101 from cycle 1.
  - spi_start pulse at cycle 4 with spi_data_in=0xA5.
  - m_tdata slice1=0x3C, m_tlast[1]=1.
  - cs_n back to 4'b1111 CS_HOLD_CYC cycles after the m handshake.
- Multi-byte packet, req0 sends 0x9F,0x00,0x00 (tlast on the third byte) with m_tready stalled 5 cycles per response:
  - Three spi_start pulses; cs_n[0] stays low continuously.
  - No second spi_start while m_tvalid[0]=1.
- Round-robin, all four requesters valid with one-byte packets from reset: grant order 0,1,2,3. With req0 and req2 re-requesting immediately, the next grants are 0 then 2.
- Mid-packet stall, req2 sends a byte without tlast and then drops tvalid for 20 cycles while req3 is valid:
  - Stays in LOAD, cs_n=4'b1011, req3 not granted.
  - Packet resumes and completes when req2 reasserts.
- Reset during XFER of req1: cs_n=4'b1111, busy=0, all m_tvalid=0 immediately (async). A stray spi_done after reset produces no m_tvalid.
